branch_resolver: RTL and testbench

- Parametrised successor to the combinational jump decider. Resolves conditional and unconditional jumps plus CALL/RET, using signed condition tests.
- Registers its decision, drives the PC write strobe and target, and holds off new requests while the fetch pipeline is flushed.
- Contains a circular return-address stack (RAS). Sits between decode and the PC register.

---
 rtl/branch_resolver_if.sv | 31 +++
 rtl/branch_resolver.sv | 192 +++++++++++++++++++
 tb/tb_branch_resolver.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolver_if.sv
// Decode <-> branch resolver handshake: jump request in, registered PC decision and RAS status out.
interface branch_resolver_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 16
);
   logic              req_valid;
   logic              req_ready;
   logic [2:0]        jump_op;
   logic [DATA_W-1:0] test_value;
   logic [ADDR_W-1:0] dest_addr;
   logic [ADDR_W-1:0] ret_addr;
   logic              err_clear;
   logic              resp_valid;
   logic              pc_write_enabled;
   logic [ADDR_W-1:0] pc_next;
   logic              flush;
   logic              ras_overflow;
   logic              ras_underflow;

   modport master (
      output req_valid, jump_op, test_value, dest_addr, ret_addr, err_clear,
      input  req_ready, resp_valid, pc_write_enabled, pc_next, flush,
             ras_overflow, ras_underflow
   );

   modport slave (
      input  req_valid, jump_op, test_value, dest_addr, ret_addr, err_clear,
      output req_ready, resp_valid, pc_write_enabled, pc_next, flush,
             ras_overflow, ras_underflow
   );
endinterface

// File: rtl/branch_resolver.sv
// Resolves JMP/conditional/CALL/RET requests into a registered PC write, with a circular
// return-address stack and a fixed-length fetch flush after every taken branch.
module branch_resolver #(
   parameter int unsigned DATA_W       = 16,
   parameter int unsigned ADDR_W       = 16,
   parameter int unsigned RAS_DEPTH    = 8,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   branch_resolver_if.slave  bus
);

   localparam int unsigned PTR_W  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int unsigned CNT_W  = $clog2(RAS_DEPTH + 1);
   localparam int unsigned FCNT_W = $clog2(FLUSH_CYCLES + 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } state_e;

   typedef enum logic [2:0] {
      OP_JMP  = 3'b000,
      OP_JEZ  = 3'b001,
      OP_JNZ  = 3'b010,
      OP_JGZ  = 3'b011,
      OP_JLZ  = 3'b100,
      OP_CALL = 3'b101,
      OP_RET  = 3'b110,
      OP_NOP  = 3'b111
   } op_e;

   state_e              state_q, state_d;
   logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
   logic                ready_q, ready_d;
   logic                flush_q, flush_d;
   logic                resp_valid_q, resp_valid_d;
   logic                pcwe_q, pcwe_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [PTR_W-1:0]    ptr_q, ptr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                ovf_q, ovf_d;
   logic                udf_q, udf_d;
   logic [ADDR_W-1:0]   ras_q [RAS_DEPTH];

   logic                accept_c;
   logic                taken_c;
   logic [ADDR_W-1:0]   target_c;
   logic                push_c;
   logic                pop_c;
   logic                ovf_evt_c;
   logic                udf_evt_c;
   logic                tv_zero_c;
   logic                tv_neg_c;
   logic [PTR_W-1:0]    ptr_dec_c;
   op_e                 op_c;

   assign accept_c  = bus.req_valid & ready_q;
   assign op_c      = op_e'(bus.jump_op);
   assign tv_zero_c = (bus.test_value == '0);
   assign tv_neg_c  = bus.test_value[DATA_W-1];
   assign ptr_dec_c = ptr_q - PTR_W'(1);

   // Jump decision for the request currently on the bus (only acted on at accept).
   always_comb begin
      taken_c   = 1'b0;
      target_c  = bus.dest_addr;
      push_c    = 1'b0;
      pop_c     = 1'b0;
      ovf_evt_c = 1'b0;
      udf_evt_c = 1'b0;
      case (op_c)
         OP_JMP:  taken_c = 1'b1;
         OP_JEZ:  taken_c = tv_zero_c;
         OP_JNZ:  taken_c = ~tv_zero_c;
         OP_JGZ:  taken_c = ~tv_neg_c & ~tv_zero_c;
         OP_JLZ:  taken_c = tv_neg_c;
         OP_CALL: begin
            taken_c   = 1'b1;
            push_c    = 1'b1;
            ovf_evt_c = (cnt_q == CNT_W'(RAS_DEPTH));
         end
         OP_RET: begin
            if (cnt_q != '0) begin
               taken_c  = 1'b1;
               pop_c    = 1'b1;
               target_c = ras_q[ptr_dec_c];
            end else begin
               udf_evt_c = 1'b1;
            end
         end
         default: taken_c = 1'b0;
      endcase
   end

   // RAS pointer/count; a full stack keeps its count and overwrites the oldest slot.
   always_comb begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      if (accept_c && push_c) begin
         ptr_d = ptr_q + PTR_W'(1);
         if (!ovf_evt_c) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (accept_c && pop_c) begin
         ptr_d = ptr_dec_c;
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Flush sequencing: FLUSH lasts FLUSH_CYCLES cycles starting with the PC write pulse.
   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_c && taken_c) begin
               state_d = ST_FLUSH;
               fcnt_d  = FCNT_W'(FLUSH_CYCLES);
            end
         end
         ST_FLUSH: begin
            if (fcnt_q <= FCNT_W'(1)) begin
               state_d = ST_IDLE;
               fcnt_d  = '0;
            end else begin
               fcnt_d = fcnt_q - FCNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            fcnt_d  = '0;
         end
      endcase
   end

   always_comb begin
      ready_d      = (state_d == ST_IDLE);
      flush_d      = (state_d == ST_FLUSH);
      resp_valid_d = accept_c;
      pcwe_d       = accept_c & taken_c;
      pc_d         = (accept_c && taken_c) ? target_c : pc_q;
      // A new error in the clearing cycle wins over err_clear.
      ovf_d        = (ovf_q & ~bus.err_clear) | (accept_c & ovf_evt_c);
      udf_d        = (udf_q & ~bus.err_clear) | (accept_c & udf_evt_c);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         fcnt_q       <= '0;
         ready_q      <= 1'b0;
         flush_q      <= 1'b0;
         resp_valid_q <= 1'b0;
         pcwe_q       <= 1'b0;
         pc_q         <= '0;
         ptr_q        <= '0;
         cnt_q        <= '0;
         ovf_q        <= 1'b0;
         udf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         fcnt_q       <= fcnt_d;
         ready_q      <= ready_d;
         flush_q      <= flush_d;
         resp_valid_q <= resp_valid_d;
         pcwe_q       <= pcwe_d;
         pc_q         <= pc_d;
         ptr_q        <= ptr_d;
         cnt_q        <= cnt_d;
         ovf_q        <= ovf_d;
         udf_q        <= udf_d;
      end
   end

   // Stack storage carries no reset; only pointer and count define its contents.
   always_ff @(posedge clk) begin
      if (accept_c && push_c) begin
         ras_q[ptr_q] <= bus.ret_addr;
      end
   end

   assign bus.req_ready        = ready_q;
   assign bus.resp_valid       = resp_valid_q;
   assign bus.pc_write_enabled = pcwe_q;
   assign bus.pc_next          = pc_q;
   assign bus.flush            = flush_q;
   assign bus.ras_overflow     = ovf_q;
   assign bus.ras_underflow    = udf_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: condition vector table plus RAS, flush and reset sequences.
module tb_branch_resolver;

   localparam int unsigned DW = 16;
   localparam int unsigned AW = 16;

   localparam logic [2:0] JMP  = 3'b000;
   localparam logic [2:0] JEZ  = 3'b001;
   localparam logic [2:0] JNZ  = 3'b010;
   localparam logic [2:0] JGZ  = 3'b011;
   localparam logic [2:0] JLZ  = 3'b100;
   localparam logic [2:0] CALL = 3'b101;
   localparam logic [2:0] RET  = 3'b110;
   localparam logic [2:0] NOP  = 3'b111;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   branch_resolver_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   branch_resolver #(
      .DATA_W(DW), .ADDR_W(AW), .RAS_DEPTH(8), .FLUSH_CYCLES(2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic          taken;
      logic [AW-1:0] pc;
      int            resp_cyc;
      int            id;
   } exp_t;

   typedef struct {
      logic [2:0]    op;
      logic [DW-1:0] tv;
      logic [AW-1:0] dest;
      logic          taken;
   } vec_t;

   exp_t          sb[$];
   exp_t          mon_e;
   vec_t          vecs[12];
   int            tests   = 0;
   int            fails   = 0;
   int            cyc     = 0;
   int            next_id = 0;
   logic [AW-1:0] last_pc = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk_b(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_w(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%04h expected 0x%04h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_i(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Response monitor: pops the scoreboard on every resp_valid pulse.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.resp_valid) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_resp: got resp_valid=1 expected no response (t=%0t)", $time);
            end else begin
               mon_e = sb.pop_front();
               chk_b($sformatf("resp%0d_pcwe", mon_e.id), bus.pc_write_enabled, mon_e.taken);
               chk_w($sformatf("resp%0d_pc_next", mon_e.id), bus.pc_next, mon_e.pc);
               chk_i($sformatf("resp%0d_latency_cycle", mon_e.id), cyc, mon_e.resp_cyc);
            end
         end else if (bus.pc_write_enabled) begin
            tests++;
            fails++;
            $display("FAIL stray_pcwe: got pc_write_enabled=1 expected 0 without resp_valid (t=%0t)", $time);
         end
      end
   end

   task automatic send(input logic [2:0] op, input logic [DW-1:0] tv, input logic [AW-1:0] dest,
                       input logic [AW-1:0] ra, input logic clr, input logic exp_taken,
                       input logic [AW-1:0] exp_target, output int acc_cyc);
      int waited = 0;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.jump_op    = op;
      bus.test_value = tv;
      bus.dest_addr  = dest;
      bus.ret_addr   = ra;
      bus.err_clear  = clr;
      #1;
      while (!bus.req_ready && waited < 20) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (!bus.req_ready) begin
         tests++;
         fails++;
         $display("FAIL ready_timeout: got req_ready=0 for %0d cycles expected 1", waited);
         bus.req_valid = 1'b0;
         bus.err_clear = 1'b0;
         acc_cyc = -1;
         return;
      end
      acc_cyc = cyc + 1;
      sb.push_back('{taken: exp_taken, pc: (exp_taken ? exp_target : last_pc),
                     resp_cyc: cyc + 1, id: next_id});
      if (exp_taken) last_pc = exp_target;
      next_id++;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.err_clear = 1'b0;
      bus.jump_op   = NOP;
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      bus.err_clear = 1'b1;
      @(negedge clk);
      bus.err_clear = 1'b0;
      #1;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      #2;
      chk_i("scoreboard_drained", sb.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no end of test expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int a1, a2, acc;

      vecs[0]  = '{JGZ, 16'h8000, 16'h1000, 1'b0};
      vecs[1]  = '{JLZ, 16'h8000, 16'h1001, 1'b1};
      vecs[2]  = '{JEZ, 16'h0000, 16'h1002, 1'b1};
      vecs[3]  = '{JEZ, 16'h0001, 16'h1003, 1'b0};
      vecs[4]  = '{JNZ, 16'h0000, 16'h1004, 1'b0};
      vecs[5]  = '{JNZ, 16'h00FF, 16'h1005, 1'b1};
      vecs[6]  = '{JGZ, 16'h7FFF, 16'h1006, 1'b1};
      vecs[7]  = '{JGZ, 16'h0000, 16'h1007, 1'b0};
      vecs[8]  = '{JGZ, 16'h0001, 16'h1008, 1'b1};
      vecs[9]  = '{JLZ, 16'h7FFF, 16'h1009, 1'b0};
      vecs[10] = '{JLZ, 16'hFFFF, 16'h100A, 1'b1};
      vecs[11] = '{NOP, 16'h0000, 16'h100B, 1'b0};

      bus.req_valid  = 1'b0;
      bus.jump_op    = NOP;
      bus.test_value = '0;
      bus.dest_addr  = '0;
      bus.ret_addr   = '0;
      bus.err_clear  = 1'b0;

      // Reset values
      repeat (2) @(negedge clk);
      chk_b("rst_resp_valid", bus.resp_valid, 1'b0);
      chk_b("rst_pcwe", bus.pc_write_enabled, 1'b0);
      chk_w("rst_pc_next", bus.pc_next, 16'h0000);
      chk_b("rst_flush", bus.flush, 1'b0);
      chk_b("rst_ovf", bus.ras_overflow, 1'b0);
      chk_b("rst_udf", bus.ras_underflow, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk_b("ready_after_release", bus.req_ready, 1'b1);

      // Signed boundary: JGZ 0x8000 not taken, JLZ 0x8000 taken with 2-cycle flush
      send(JGZ, 16'h8000, 16'h0ABC, 16'h0, 1'b0, 1'b0, 16'h0ABC, acc);
      send(JLZ, 16'h8000, 16'h1234, 16'h0, 1'b0, 1'b1, 16'h1234, acc);
      @(negedge clk); #1;
      chk_b("flush_c1", bus.flush, 1'b1);
      chk_b("ready_c1", bus.req_ready, 1'b0);
      @(negedge clk); #1;
      chk_b("flush_c2", bus.flush, 1'b1);
      chk_b("ready_c2", bus.req_ready, 1'b0);
      @(negedge clk); #1;
      chk_b("flush_c3", bus.flush, 1'b0);
      chk_b("ready_c3", bus.req_ready, 1'b1);

      // Back-to-back not-taken accepts
      send(JEZ, 16'h0001, 16'h2000, 16'h0, 1'b0, 1'b0, 16'h2000, a1);
      send(JNZ, 16'h0000, 16'h2001, 16'h0, 1'b0, 1'b0, 16'h2001, a2);
      chk_i("back_to_back_accept", a2, a1 + 1);

      // Condition table
      for (int i = 0; i < 12; i++) begin
         send(vecs[i].op, vecs[i].tv, vecs[i].dest, 16'h0, 1'b0, vecs[i].taken, vecs[i].dest, acc);
      end
      drain();

      // CALL / RET / RET underflow
      send(CALL, 16'h0, 16'h0100, 16'h0011, 1'b0, 1'b1, 16'h0100, acc);
      send(RET,  16'h0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0011, acc);
      send(RET,  16'h0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, acc);
      chk_b("udf_after_empty_ret", bus.ras_underflow, 1'b1);
      chk_b("ovf_still_clear", bus.ras_overflow, 1'b0);

      // err_clear vs. simultaneous underflow
      pulse_clear();
      chk_b("udf_cleared", bus.ras_underflow, 1'b0);
      send(RET, 16'h0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, acc);
      chk_b("udf_set_wins_over_clear", bus.ras_underflow, 1'b1);
      pulse_clear();
      chk_b("udf_cleared_again", bus.ras_underflow, 1'b0);

      // Overflow: 9 CALLs into 8 entries, then unwind
      for (int i = 1; i <= 9; i++) begin
         send(CALL, 16'h0, AW'(16'h0200 + i), AW'(i), 1'b0, 1'b1, AW'(16'h0200 + i), acc);
         if (i == 8) chk_b("ovf_clear_at_full", bus.ras_overflow, 1'b0);
      end
      chk_b("ovf_after_9_calls", bus.ras_overflow, 1'b1);
      for (int k = 1; k <= 8; k++) begin
         send(RET, 16'h0, 16'h0000, 16'h0000, 1'b0, 1'b1, AW'(10 - k), acc);
      end
      chk_b("udf_before_9th_ret", bus.ras_underflow, 1'b0);
      send(RET, 16'h0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, acc);
      chk_b("udf_after_9th_ret", bus.ras_underflow, 1'b1);
      drain();

      // Reset during flush, with a pushed entry that the reset must forget
      send(CALL, 16'h0, 16'h0500, 16'h0055, 1'b0, 1'b1, 16'h0500, acc);
      send(JMP, 16'h0, 16'h0777, 16'h0000, 1'b0, 1'b1, 16'h0777, acc);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_b("midflush_rst_flush", bus.flush, 1'b0);
      chk_b("midflush_rst_pcwe", bus.pc_write_enabled, 1'b0);
      chk_b("midflush_rst_resp", bus.resp_valid, 1'b0);
      chk_w("midflush_rst_pc", bus.pc_next, 16'h0000);
      chk_b("midflush_rst_udf", bus.ras_underflow, 1'b0);
      last_pc = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk_b("ready_one_clk_after_release", bus.req_ready, 1'b1);
      send(RET, 16'h0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, acc);
      chk_b("udf_ret_after_reset", bus.ras_underflow, 1'b1);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
